// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: register-file geometry, tag width and
// the register-status-table entry payload.
package mips_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned REG_ADDR_W = 5;

  // One register-status-table entry: pending flag plus producing RS tag.
  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } rst_entry_t;

endpackage

// File: rtl/rst_entry.sv
// Single register-status-table entry.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   flush           - squash: drop pending state (tag kept)
//   dispatch_sel    - this register is the destination of the issuing instr
//   dispatch_tag    - producer tag recorded on dispatch
//   cdb_valid/tag   - common data bus broadcast
//   entry           - current {busy, tag}
//   hit_c           - broadcast retires this entry this cycle (dispatch-masked)
module rst_entry
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             dispatch_sel,
  input  logic [TAG_W-1:0] dispatch_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output rst_entry_t       entry,
  output logic             hit_c
);

  // A same-cycle dispatch installs a newer producer, so it suppresses the hit.
  always_comb begin
    hit_c = entry.busy && cdb_valid && (entry.tag == cdb_tag) && !dispatch_sel;
  end

  // Entry state: reset > flush > dispatch > CDB retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry <= '0;
    end else if (flush) begin
      entry.busy <= 1'b0;
    end else if (dispatch_sel) begin
      entry.busy <= 1'b1;
      entry.tag  <= dispatch_tag;
    end else if (hit_c) begin
      entry.busy <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_status_table.sv
// Tomasulo register status table for the 32-entry MIPS register file.
// Tracks which registers await a result and which RS tag produces it,
// retires entries on CDB broadcasts and emits a registered one-hot clear
// vector for the downstream 32-to-5 encoder.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   flush                        - invalidate all pending entries
//   dispatch_en/rd/tag           - destination allocation for issuing instr
//   rs_addr/rt_addr              - source read addresses
//   rs_busy/rs_tag, rt_busy/rt_tag - combinational read results (CDB-forwarded)
//   cdb_valid/cdb_tag            - common data bus broadcast
//   wen1_rst                     - registered one-hot clear vector
//   multi_match_err              - sticky: a broadcast hit more than one entry
module reg_status_table
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  dispatch_en,
  input  logic [REG_ADDR_W-1:0] dispatch_rd,
  input  logic [TAG_W-1:0]      dispatch_tag,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  rs_busy,
  output logic [TAG_W-1:0]      rs_tag,
  output logic                  rt_busy,
  output logic [TAG_W-1:0]      rt_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  output logic [NUM_REGS-1:0]   wen1_rst,
  output logic                  multi_match_err
);

  rst_entry_t             entries [NUM_REGS];
  logic [NUM_REGS-1:0]    dispatch_sel_c;
  logic [NUM_REGS-1:0]    hit_c;
  logic [NUM_REGS-1:0]    hit_masked_c;
  logic                   multi_hit_c;
  rst_entry_t             rs_ent_c;
  rst_entry_t             rt_ent_c;

  // Destination decode; $zero is never allocated.
  always_comb begin
    dispatch_sel_c = '0;
    if (dispatch_en && (dispatch_rd != '0)) begin
      dispatch_sel_c[dispatch_rd] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    rst_entry u_entry (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .dispatch_sel (dispatch_sel_c[i]),
      .dispatch_tag (dispatch_tag),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .entry        (entries[i]),
      .hit_c        (hit_c[i])
    );
  end

  // Bit 0 is hard-masked so the encoder never sees a $zero clear.
  always_comb begin
    hit_masked_c = hit_c & ~NUM_REGS'(1);
    multi_hit_c  = |(hit_masked_c & (hit_masked_c - NUM_REGS'(1)));
  end

  // Clear vector and sticky multi-match flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen1_rst        <= '0;
      multi_match_err <= 1'b0;
    end else if (flush) begin
      wen1_rst        <= '0;
    end else begin
      wen1_rst <= hit_masked_c;
      if (multi_hit_c) begin
        multi_match_err <= 1'b1;
      end
    end
  end

  // Read ports with CDB forwarding; no dispatch bypass.
  always_comb begin
    rs_ent_c = entries[rs_addr];
    rt_ent_c = entries[rt_addr];
    rs_busy  = 1'b0;
    rs_tag   = '0;
    rt_busy  = 1'b0;
    rt_tag   = '0;
    if (rs_addr != '0) begin
      rs_busy = rs_ent_c.busy && !(cdb_valid && (cdb_tag == rs_ent_c.tag));
      rs_tag  = rs_ent_c.tag;
    end
    if (rt_addr != '0) begin
      rt_busy = rt_ent_c.busy && !(cdb_valid && (cdb_tag == rt_ent_c.tag));
      rt_tag  = rt_ent_c.tag;
    end
  end

endmodule
